// File: rtl/fetch_unit.sv
// PC owner and fetch sequencer in front of a synchronous-read instruction BRAM.
// Hides the one-cycle read latency, skids the instruction under stall, one bubble per redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  output logic              instr_valid_o,
  output logic              misaligned_err_o
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic        misaligned_err_q, misaligned_err_d;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    resp_pc_d        = resp_pc_q;
    resp_valid_d     = resp_valid_q;
    hold_instr_d     = hold_instr_q;
    hold_valid_d     = hold_valid_q;
    misaligned_err_d = misaligned_err_q;

    if (redirect_i) begin
      // Redirect wins over stall; the in-flight wrong-path fetch is dropped.
      fetch_pc_d       = {redirect_pc_i[31:2], 2'b00};
      resp_valid_d     = 1'b0;
      hold_valid_d     = 1'b0;
      misaligned_err_d = misaligned_err_q | (redirect_pc_i[1:0] != 2'b00);
    end else if (stall_i) begin
      // Only the first stall cycle sees data for resp_pc; later cycles re-read fetch_pc.
      if (resp_valid_q && !hold_valid_q) begin
        hold_instr_d = imem_rdata_i;
        hold_valid_d = 1'b1;
      end
    end else begin
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      fetch_pc_d   = fetch_pc_q + 32'd4;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q       <= RESET_PC;
      resp_pc_q        <= 32'd0;
      resp_valid_q     <= 1'b0;
      hold_instr_q     <= 32'd0;
      hold_valid_q     <= 1'b0;
      misaligned_err_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      resp_pc_q        <= resp_pc_d;
      resp_valid_q     <= resp_valid_d;
      hold_instr_q     <= hold_instr_d;
      hold_valid_q     <= hold_valid_d;
      misaligned_err_q <= misaligned_err_d;
    end
  end

  assign imem_addr_o      = fetch_pc_q[ADDR_W+1:2];
  assign instr_o          = hold_valid_q ? hold_instr_q : imem_rdata_i;
  assign instr_pc_o       = resp_pc_q;
  assign instr_valid_o    = resp_valid_q;
  assign misaligned_err_o = misaligned_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus randomized run against a PC-stream model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned ADDR_W   = 14;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              stall_i = 1'b0;
  logic              redirect_i = 1'b0;
  logic [31:0]       redirect_pc_i = 32'd0;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic [31:0]       instr_o;
  logic [31:0]       instr_pc_o;
  logic              instr_valid_o;
  logic              misaligned_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // model: the architectural instruction stream, not the pipeline registers
  logic [31:0] m_next_pc;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_err;

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_valid_o    (instr_valid_o),
    .misaligned_err_o (misaligned_err_o)
  );

  always #5 clk = ~clk;

  // synchronous-read memory, word n holds 32'h1000_0000 + n
  always @(posedge clk) imem_rdata_i <= 32'h1000_0000 + 32'(imem_addr_o);

  function automatic logic [31:0] mem_word_for_pc(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc / 4) % (32'd1 << ADDR_W));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
    reset_i       = rst;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    @(posedge clk);
    if (rst) begin
      m_next_pc = RESET_PC;
      m_pc      = 32'd0;
      m_valid   = 1'b0;
      m_err     = 1'b0;
    end else if (rd) begin
      m_next_pc = rpc & ~32'd3;
      m_valid   = 1'b0;
      m_err     = m_err | (rpc % 4 != 0);
    end else if (!st) begin
      m_pc      = m_next_pc;
      m_valid   = 1'b1;
      m_next_pc = m_next_pc + 32'd4;
    end
    #1;
    check("model_valid", 32'(instr_valid_o), 32'(m_valid));
    check("model_pc", instr_pc_o, m_pc);
    check("model_err", 32'(misaligned_err_o), 32'(m_err));
    check("model_addr", 32'(imem_addr_o), (m_next_pc / 4) % (32'd1 << ADDR_W));
    if (m_valid) check("model_instr", instr_o, mem_word_for_pc(m_pc));
  endtask

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                              input logic eerr);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eerr = eerr;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    m_next_pc = RESET_PC;
    m_pc      = 32'd0;
    m_valid   = 1'b0;
    m_err     = 1'b0;

    //                 rst st rd target         valid pc            instr          err
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,         32'h1000_0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h4,         32'h1000_0001, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h8,         32'h1000_0002, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,         32'h1000_0002, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,         32'h1000_0002, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,         32'h1000_0002, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC,         32'h1000_0003, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h10,        32'h1000_0004, 0));
    vecs.push_back(mk(0, 0, 1, 32'h40,         0, 32'h10,        32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h40,        32'h1000_0010, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h44,        32'h1000_0011, 0));
    vecs.push_back(mk(0, 1, 1, 32'h80,         0, 32'h44,        32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h80,        32'h1000_0020, 0));
    vecs.push_back(mk(0, 0, 1, 32'h22,         0, 32'h80,        32'h0,         1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h20,        32'h1000_0008, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h24,        32'h1000_0009, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h24,        32'h1000_0009, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,         32'h1000_0000, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h4,         32'h1000_0001, 0));
    vecs.push_back(mk(0, 0, 1, 32'h100,        0, 32'h4,         32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 32'h4,         32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 32'h4,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h100,       32'h1000_0040, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,  0, 32'h100,       32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h1000_3FFF, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,         32'h1000_0000, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0001_0010,  0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0001_0010, 32'h1000_0004, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rpc);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid_o), 32'(vecs[i].ev));
      check($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].epc);
      check($sformatf("vec%0d_err", i), 32'(misaligned_err_o), 32'(vecs[i].eerr));
      if (vecs[i].ev) check($sformatf("vec%0d_instr", i), instr_o, vecs[i].einstr);
    end

    // outputs during the redirect cycle still show the pre-redirect instruction
    step(0, 0, 0, 32'h0);
    reset_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    check("redir_cycle_valid", 32'(instr_valid_o), 32'd1);
    check("redir_cycle_pc", instr_pc_o, 32'h0001_0014);
    check("redir_cycle_instr", instr_o, 32'h1000_0005);
    step(0, 0, 1, 32'h200);
    step(0, 0, 0, 32'h0);
    check("after_redir_pc", instr_pc_o, 32'h200);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(99) < 2);
      r_rd  = ($urandom_range(99) < 10);
      r_st  = ($urandom_range(99) < 35);
      r_pc  = $urandom;
      if ($urandom_range(3) != 0) r_pc[1:0] = 2'b00;
      step(r_rst, r_st, r_rd, r_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
